// File: rtl/router_fsm_ctrl.sv
// Input-side control sequencer for the 1x3 router: header decode, load/full/parity phases, FIFO write enables.
// Latency: Moore strobes one cycle after the sampled inputs; write_enb decoded from state and latched address only.
// Backpressure: busy stalls the source outside DA/LD; per-port read timeout issues one-cycle soft_reset flush pulses.
module router_fsm_ctrl (
    input  logic       clk,
    input  logic       reset,
    input  logic       packet_valid,
    input  logic [1:0] data_in,
    input  logic       fifo_full,
    input  logic       fifo_empty_0,
    input  logic       fifo_empty_1,
    input  logic       fifo_empty_2,
    input  logic       vld_out_0,
    input  logic       vld_out_1,
    input  logic       vld_out_2,
    input  logic       read_enb_0,
    input  logic       read_enb_1,
    input  logic       read_enb_2,
    input  logic       parity_done,
    input  logic       low_packet_valid,
    output logic       detect_add,
    output logic       lfd_state,
    output logic       ld_state,
    output logic       laf_state,
    output logic       full_state,
    output logic       rst_int_reg,
    output logic       write_enb_reg,
    output logic [2:0] write_enb,
    output logic       busy,
    output logic       soft_reset_0,
    output logic       soft_reset_1,
    output logic       soft_reset_2
);

    // State encoding kept as plain constants so older tools and scripts can match on values.
    localparam logic [2:0] ST_DA  = 3'd0;  // decode address
    localparam logic [2:0] ST_LFD = 3'd1;  // load first data
    localparam logic [2:0] ST_LD  = 3'd2;  // load data
    localparam logic [2:0] ST_FFS = 3'd3;  // fifo full stall
    localparam logic [2:0] ST_LAF = 3'd4;  // load after full
    localparam logic [2:0] ST_LP  = 3'd5;  // load parity
    localparam logic [2:0] ST_CPE = 3'd6;  // check parity error
    localparam logic [2:0] ST_WTE = 3'd7;  // wait till empty

    // A port that has sat valid-but-unread for this many prior cycles gets flushed on the next idle one.
    localparam logic [4:0] TMO_LAST = 5'd29;

    logic [2:0]      state_q, state_d;
    logic [1:0]      addr_q, addr_d;
    logic [2:0][4:0] tmo_cnt_q, tmo_cnt_d;
    logic [2:0]      soft_reset_q, soft_reset_d;

    // Port-indexed views; the spare bit 3 covers the invalid address 3 and is never selected in practice.
    logic [3:0] fifo_empty_v;
    logic [3:0] soft_reset_v;
    logic [2:0] vld_out_v;
    logic [2:0] read_enb_v;
    logic       hdr_ok;
    logic       flush_cur;

    assign fifo_empty_v = {1'b0, fifo_empty_2, fifo_empty_1, fifo_empty_0};
    assign soft_reset_v = {1'b0, soft_reset_q};
    assign vld_out_v    = {vld_out_2, vld_out_1, vld_out_0};
    assign read_enb_v   = {read_enb_2, read_enb_1, read_enb_0};

    // Address 3 has no output port, so such a header is simply ignored.
    assign hdr_ok    = packet_valid && (data_in != 2'd3);
    // A flush of the port we are currently feeding abandons the packet.
    assign flush_cur = soft_reset_v[addr_q];

    // Next-state and address-latch decision.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        case (state_q)
            ST_DA: begin
                if (hdr_ok) begin
                    addr_d  = data_in;
                    state_d = fifo_empty_v[data_in] ? ST_LFD : ST_WTE;
                end
            end
            ST_LFD: state_d = ST_LD;
            ST_LD: begin
                if (fifo_full) begin
                    state_d = ST_FFS;
                end else if (!packet_valid) begin
                    state_d = ST_LP;
                end
            end
            ST_FFS: begin
                if (!fifo_full) begin
                    state_d = ST_LAF;
                end
            end
            ST_LAF: begin
                if (parity_done) begin
                    state_d = ST_DA;
                end else if (low_packet_valid) begin
                    state_d = ST_LP;
                end else begin
                    state_d = ST_LD;
                end
            end
            ST_LP:  state_d = ST_CPE;
            ST_CPE: state_d = fifo_full ? ST_FFS : ST_DA;
            ST_WTE: begin
                if (fifo_empty_v[addr_q]) begin
                    state_d = ST_LFD;
                end
            end
            default: state_d = ST_DA;
        endcase
        if (flush_cur && (state_q != ST_DA)) begin
            state_d = ST_DA;
        end
    end

    // Per-port read timeout: count idle-valid cycles, fire one flush pulse and restart on the 30th.
    always_comb begin
        tmo_cnt_d    = '0;
        soft_reset_d = '0;
        for (int i = 0; i < 3; i++) begin
            if (vld_out_v[i] && !read_enb_v[i]) begin
                if (tmo_cnt_q[i] == TMO_LAST) begin
                    soft_reset_d[i] = 1'b1;
                end else begin
                    tmo_cnt_d[i] = tmo_cnt_q[i] + 5'd1;
                end
            end
        end
    end

    // Sequencer state and latched destination port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= ST_DA;
            addr_q  <= 2'd0;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
        end
    end

    // Timeout counters and registered flush pulses.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q    <= '0;
            soft_reset_q <= '0;
        end else begin
            tmo_cnt_q    <= tmo_cnt_d;
            soft_reset_q <= soft_reset_d;
        end
    end

    // Moore strobes straight from the state register; no input reaches an output combinationally.
    assign detect_add    = (state_q == ST_DA);
    assign lfd_state     = (state_q == ST_LFD);
    assign ld_state      = (state_q == ST_LD);
    assign laf_state     = (state_q == ST_LAF);
    assign full_state    = (state_q == ST_FFS);
    assign rst_int_reg   = (state_q == ST_CPE);
    assign write_enb_reg = (state_q == ST_LD) || (state_q == ST_LAF) || (state_q == ST_LP);
    assign busy          = !((state_q == ST_DA) || (state_q == ST_LD));
    assign write_enb     = write_enb_reg ? (3'b001 << addr_q) : 3'b000;

    assign soft_reset_0 = soft_reset_q[0];
    assign soft_reset_1 = soft_reset_q[1];
    assign soft_reset_2 = soft_reset_q[2];

endmodule

// File: tb/tb_router_fsm_ctrl.sv
// Bench for router_fsm_ctrl: vector table, directed reset/timeout sequences, random run against a phase model.
// Outputs are sampled 1 time unit after each rising edge; inputs change only at that point too.
// Flush behaviour is modelled as a run length of idle-valid cycles per port.
module tb_router_fsm_ctrl;

    typedef enum int {M_DA, M_LFD, M_LD, M_FFS, M_LAF, M_LP, M_CPE, M_WTE} mph_t;

    typedef struct {
        logic       pv;
        logic [1:0] din;
        logic       full;
        logic [2:0] fe;
        logic       lpv;
        logic       pd;
        mph_t       ph;
        int         addr;
    } vec_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       packet_valid;
    logic [1:0] data_in;
    logic       fifo_full;
    logic       fifo_empty_0, fifo_empty_1, fifo_empty_2;
    logic       vld_out_0, vld_out_1, vld_out_2;
    logic       read_enb_0, read_enb_1, read_enb_2;
    logic       parity_done;
    logic       low_packet_valid;
    logic       detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg;
    logic       write_enb_reg;
    logic [2:0] write_enb;
    logic       busy;
    logic       soft_reset_0, soft_reset_1, soft_reset_2;

    int n_vec = 0;
    int n_bad = 0;

    // Reference model state
    mph_t       m_ph;
    int         m_addr;
    int         m_run [3];
    logic [2:0] m_sr;

    vec_t tbl[$];

    always #5 clk = ~clk;

    router_fsm_ctrl dut (
        .clk(clk), .reset(reset), .packet_valid(packet_valid), .data_in(data_in),
        .fifo_full(fifo_full), .fifo_empty_0(fifo_empty_0), .fifo_empty_1(fifo_empty_1),
        .fifo_empty_2(fifo_empty_2), .vld_out_0(vld_out_0), .vld_out_1(vld_out_1),
        .vld_out_2(vld_out_2), .read_enb_0(read_enb_0), .read_enb_1(read_enb_1),
        .read_enb_2(read_enb_2), .parity_done(parity_done), .low_packet_valid(low_packet_valid),
        .detect_add(detect_add), .lfd_state(lfd_state), .ld_state(ld_state),
        .laf_state(laf_state), .full_state(full_state), .rst_int_reg(rst_int_reg),
        .write_enb_reg(write_enb_reg), .write_enb(write_enb), .busy(busy),
        .soft_reset_0(soft_reset_0), .soft_reset_1(soft_reset_1), .soft_reset_2(soft_reset_2)
    );

    logic [13:0] dut_vec;
    assign dut_vec = {detect_add, lfd_state, ld_state, laf_state, full_state, rst_int_reg,
                      write_enb_reg, write_enb, busy, soft_reset_2, soft_reset_1, soft_reset_0};

    function automatic logic [13:0] expect_vec(mph_t ph, int a, logic [2:0] sr);
        logic [13:0] v;
        logic        loading;
        logic [2:0]  one;
        v       = '0;
        one     = 3'b001;
        loading = (ph == M_LD) || (ph == M_LAF) || (ph == M_LP);
        v[13]   = (ph == M_DA);
        v[12]   = (ph == M_LFD);
        v[11]   = (ph == M_LD);
        v[10]   = (ph == M_LAF);
        v[9]    = (ph == M_FFS);
        v[8]    = (ph == M_CPE);
        v[7]    = loading;
        v[6:4]  = loading ? (one << a) : 3'b000;
        v[3]    = !((ph == M_DA) || (ph == M_LD));
        v[2:0]  = sr;
        return v;
    endfunction

    function automatic vec_t mk(logic pv, logic [1:0] din, logic full, logic [2:0] fe,
                                logic lpv, logic pd, mph_t ph, int addr);
        vec_t r;
        r.pv = pv; r.din = din; r.full = full; r.fe = fe;
        r.lpv = lpv; r.pd = pd; r.ph = ph; r.addr = addr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_ph   = M_DA;
        m_addr = 0;
        m_sr   = 3'b000;
        for (int i = 0; i < 3; i++) m_run[i] = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        mph_t       nx;
        int         na;
        logic [2:0] fe;
        logic [2:0] vl;
        logic [2:0] rd;
        logic [2:0] nsr;
        fe  = {fifo_empty_2, fifo_empty_1, fifo_empty_0};
        vl  = {vld_out_2, vld_out_1, vld_out_0};
        rd  = {read_enb_2, read_enb_1, read_enb_0};
        nx  = m_ph;
        na  = m_addr;
        nsr = 3'b000;
        case (m_ph)
            M_DA:  if (packet_valid && data_in != 2'd3) begin
                       na = int'(data_in);
                       nx = fe[na] ? M_LFD : M_WTE;
                   end
            M_LFD: nx = M_LD;
            M_LD:  nx = fifo_full ? M_FFS : (!packet_valid ? M_LP : M_LD);
            M_FFS: nx = fifo_full ? M_FFS : M_LAF;
            M_LAF: nx = parity_done ? M_DA : (low_packet_valid ? M_LP : M_LD);
            M_LP:  nx = M_CPE;
            M_CPE: nx = fifo_full ? M_FFS : M_DA;
            M_WTE: nx = fe[m_addr] ? M_LFD : M_WTE;
            default: nx = M_DA;
        endcase
        if (m_ph != M_DA && m_sr[m_addr]) nx = M_DA;
        for (int i = 0; i < 3; i++) begin
            if (vl[i] && !rd[i]) begin
                m_run[i]++;
                if (m_run[i] == 30) begin
                    nsr[i]   = 1'b1;
                    m_run[i] = 0;
                end
            end else begin
                m_run[i] = 0;
            end
        end
        m_ph   = nx;
        m_addr = na;
        m_sr   = nsr;
    endtask

    task automatic tick(input string name);
        @(posedge clk);
        model_step();
        #1;
        chk(name, 32'(dut_vec), 32'(expect_vec(m_ph, m_addr, m_sr)));
    endtask

    task automatic idle_inputs();
        packet_valid = 1'b0; data_in = 2'd0; fifo_full = 1'b0;
        fifo_empty_0 = 1'b1; fifo_empty_1 = 1'b1; fifo_empty_2 = 1'b1;
        vld_out_0 = 1'b0; vld_out_1 = 1'b0; vld_out_2 = 1'b0;
        read_enb_0 = 1'b0; read_enb_1 = 1'b0; read_enb_2 = 1'b0;
        parity_done = 1'b0; low_packet_valid = 1'b0;
    endtask

    initial begin
        // Clean packet to port 1
        tbl.push_back(mk(1, 2'd1, 0, 3'b111, 0, 0, M_LFD, 1));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LD,  1));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LD,  1));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LD,  1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_LP,  1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_CPE, 1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_DA,  1));
        // Invalid address 3 never leaves DA
        for (int k = 0; k < 4; k++) tbl.push_back(mk(1, 2'd3, 0, 3'b111, 0, 0, M_DA, 1));
        // Port 2 not empty: wait, then full stall and LAF -> LP
        tbl.push_back(mk(1, 2'd2, 0, 3'b011, 0, 0, M_WTE, 2));
        for (int k = 0; k < 5; k++) tbl.push_back(mk(1, 2'd2, 0, 3'b011, 0, 0, M_WTE, 2));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LFD, 2));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LD,  2));
        tbl.push_back(mk(1, 2'd0, 1, 3'b111, 0, 0, M_FFS, 2));
        tbl.push_back(mk(1, 2'd0, 1, 3'b111, 0, 0, M_FFS, 2));
        tbl.push_back(mk(1, 2'd0, 1, 3'b111, 0, 0, M_FFS, 2));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LAF, 2));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 1, 0, M_LP,  2));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_CPE, 2));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_DA,  2));
        // Port 0: LAF with parity_done -> DA
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LFD, 0));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LD,  0));
        tbl.push_back(mk(1, 2'd0, 1, 3'b111, 0, 0, M_FFS, 0));
        tbl.push_back(mk(1, 2'd0, 0, 3'b111, 0, 0, M_LAF, 0));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 1, M_DA,  0));
        // Port 1: CPE with fifo_full -> FFS; parity_done beats low_packet_valid in LAF
        tbl.push_back(mk(1, 2'd1, 0, 3'b111, 0, 0, M_LFD, 1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_LD,  1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_LP,  1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_CPE, 1));
        tbl.push_back(mk(0, 2'd0, 1, 3'b111, 0, 0, M_FFS, 1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 0, 0, M_LAF, 1));
        tbl.push_back(mk(0, 2'd0, 0, 3'b111, 1, 1, M_DA,  1));

        idle_inputs();
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("reset_state", 32'(dut_vec), 32'(expect_vec(M_DA, 0, 3'b000)));
        reset = 1'b0;

        // Table-driven vectors
        for (int k = 0; k < tbl.size(); k++) begin
            packet_valid     = tbl[k].pv;
            data_in          = tbl[k].din;
            fifo_full        = tbl[k].full;
            {fifo_empty_2, fifo_empty_1, fifo_empty_0} = tbl[k].fe;
            low_packet_valid = tbl[k].lpv;
            parity_done      = tbl[k].pd;
            tick("tbl_model");
            chk($sformatf("tbl_row%0d", k), 32'(dut_vec),
                32'(expect_vec(tbl[k].ph, tbl[k].addr, 3'b000)));
        end
        idle_inputs();

        // Asynchronous reset in the middle of LD
        packet_valid = 1'b1; data_in = 2'd0;
        tick("pre_rst_lfd");
        tick("pre_rst_ld");
        chk("in_ld_before_reset", 32'(ld_state), 32'd1);
        #1 reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(dut_vec), 32'(expect_vec(M_DA, 0, 3'b000)));
        chk("async_reset_busy_we", {28'd0, busy, write_enb}, 32'd0);
        #1 reset = 1'b0;
        model_reset();
        packet_valid = 1'b0;
        tick("post_rst_idle");
        chk("post_rst_no_we", 32'(write_enb), 32'd0);

        // Timeout on port 0 while loading a packet to port 0
        packet_valid = 1'b1; data_in = 2'd0; vld_out_0 = 1'b1; read_enb_0 = 1'b0;
        for (int k = 1; k <= 31; k++) begin
            tick("tmo_model");
            if (k == 29) chk("tmo_no_pulse_29", 32'(soft_reset_0), 32'd0);
            if (k == 30) chk("tmo_pulse_30", {29'd0, soft_reset_2, soft_reset_1, soft_reset_0}, 32'd1);
            if (k == 30) chk("tmo_still_ld", 32'(ld_state), 32'd1);
            if (k == 31) chk("tmo_pulse_width", 32'(soft_reset_0), 32'd0);
            if (k == 31) chk("tmo_flush_to_da", 32'(detect_add), 32'd1);
        end
        packet_valid = 1'b0;
        vld_out_0 = 1'b0;
        tick("tmo_clear");
        vld_out_0 = 1'b1;
        for (int k = 1; k <= 45; k++) begin
            read_enb_0 = (k == 30);
            tick("tmo2_model");
            if (k >= 30) chk("tmo_read_suppress", 32'(soft_reset_0), 32'd0);
        end
        idle_inputs();

        // Randomised run against the model
        for (int k = 0; k < 1500; k++) begin
            packet_valid     = ($urandom_range(0, 9) < 7);
            data_in          = 2'($urandom_range(0, 3));
            fifo_full        = ($urandom_range(0, 9) < 2);
            fifo_empty_0     = ($urandom_range(0, 9) < 6);
            fifo_empty_1     = ($urandom_range(0, 9) < 6);
            fifo_empty_2     = ($urandom_range(0, 9) < 6);
            low_packet_valid = ($urandom_range(0, 9) < 3);
            parity_done      = ($urandom_range(0, 9) < 2);
            if ($urandom_range(0, 49) == 0) vld_out_0 = ~vld_out_0;
            if ($urandom_range(0, 49) == 0) vld_out_1 = ~vld_out_1;
            if ($urandom_range(0, 49) == 0) vld_out_2 = ~vld_out_2;
            read_enb_0 = ($urandom_range(0, 99) < 2);
            read_enb_1 = ($urandom_range(0, 99) < 2);
            read_enb_2 = ($urandom_range(0, 99) < 2);
            tick("rand_model");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
